mips_pc_sequencer: RTL and testbench

Program-counter and fetch sequencer for the Harvard MIPS core. It drives `instr_address` toward instruction memory, applies branch/jump redirects from decode after exactly one delay-slot instruction, supplies the link value for `jal`/`bltzal`/`bgezal`, and drops `active` when execution reaches the halt address. It sits directly upstream of instruction fetch and decode, and feeds the address that the instruction ROM answers.

---
 rtl/mips_pc_sequencer.sv | 101 ++++++++++
 tb/tb_mips_pc_sequencer.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/mips_pc_sequencer.sv
// PC and fetch sequencer: one-delay-slot branch redirect, link value, halt detection.
// Optional fetch counter enabled by defining MIPS_PC_INSTR_COUNT_EN.
module mips_pc_sequencer #(
  parameter logic [31:0] RESET_VECTOR = 32'hBFC00000,
  parameter logic [31:0] HALT_ADDRESS = 32'h00000000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        clk_enable,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_target,
  output logic [31:0] instr_address,
  output logic [31:0] link_address,
  output logic        in_delay_slot,
  output logic        active,
  output logic        addr_fault,
  output logic        slot_fault,
  output logic [31:0] instr_count
);

  typedef enum logic [1:0] {StRun, StSlot, StHalted} state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] target_q, target_d;
  logic        addr_fault_q, addr_fault_d;
  logic        slot_fault_q, slot_fault_d;
  logic        step;

  assign step = clk_enable && (state_q != StHalted);

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    target_d     = target_q;
    addr_fault_d = addr_fault_q;
    slot_fault_d = slot_fault_q;
    if (step) begin
      unique case (state_q)
        StRun: begin
          pc_d = pc_q + 32'd4;
          if (redirect_valid) begin
            target_d = {redirect_target[31:2], 2'b00};
            state_d  = StSlot;
            if (redirect_target[1:0] != 2'b00) addr_fault_d = 1'b1;
          end
        end
        StSlot: begin
          pc_d    = target_q;
          state_d = StRun;
          if (redirect_valid) slot_fault_d = 1'b1;
        end
        default: ;
      endcase
      // Landing on the halt address stops execution on this same edge.
      if (pc_d == HALT_ADDRESS) state_d = StHalted;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= StRun;
      pc_q         <= RESET_VECTOR;
      target_q     <= 32'd0;
      addr_fault_q <= 1'b0;
      slot_fault_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      target_q     <= target_d;
      addr_fault_q <= addr_fault_d;
      slot_fault_q <= slot_fault_d;
    end
  end

`ifdef MIPS_PC_INSTR_COUNT_EN
  logic [31:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (step) count_d = count_q + 32'd1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) count_q <= 32'd0;
    else        count_q <= count_d;
  end

  assign instr_count = count_q;
`else
  assign instr_count = 32'd0;
`endif

  assign instr_address = pc_q;
  assign link_address  = pc_q + 32'd8;
  assign in_delay_slot = (state_q == StSlot);
  assign active        = (state_q != StHalted);
  assign addr_fault    = addr_fault_q;
  assign slot_fault    = slot_fault_q;

endmodule

// File: tb/tb_mips_pc_sequencer.sv
// Randomized bench for mips_pc_sequencer against a behavioural model, plus directed scenarios.
module tb_mips_pc_sequencer;

`ifdef MIPS_PC_INSTR_COUNT_EN
  localparam bit CountEn = 1'b1;
`else
  localparam bit CountEn = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        clk_enable = 1'b1;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_target = 32'd0;
  logic [31:0] instr_address, link_address, instr_count;
  logic        in_delay_slot, active, addr_fault, slot_fault;

  int checks = 0;
  int errors = 0;
  bit cmp_en = 1'b0;

  // Behavioural model state
  logic [31:0] m_pc, m_tgt, m_cnt;
  bit          m_pend, m_active, m_af, m_sf;

  mips_pc_sequencer dut (
    .clk            (clk),
    .reset          (reset),
    .clk_enable     (clk_enable),
    .redirect_valid (redirect_valid),
    .redirect_target(redirect_target),
    .instr_address  (instr_address),
    .link_address   (link_address),
    .in_delay_slot  (in_delay_slot),
    .active         (active),
    .addr_fault     (addr_fault),
    .slot_fault     (slot_fault),
    .instr_count    (instr_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual %h required %h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: fetch advances by 4 unless a redirect taken one fetch earlier is due now.
  initial begin
    logic [31:0] nxt;
    forever begin
      @(posedge clk or negedge reset);
      if (!reset) begin
        m_pc = 32'hBFC00000; m_tgt = 32'd0; m_cnt = 32'd0;
        m_pend = 1'b0; m_active = 1'b1; m_af = 1'b0; m_sf = 1'b0;
      end else if (clk_enable && m_active) begin
        m_cnt = m_cnt + 32'd1;
        if (m_pend) begin
          nxt = m_tgt;
          m_pend = 1'b0;
          if (redirect_valid) m_sf = 1'b1;
        end else begin
          nxt = m_pc + 32'd4;
          if (redirect_valid) begin
            m_tgt = redirect_target & 32'hFFFFFFFC;
            m_pend = 1'b1;
            if (redirect_target % 4 != 0) m_af = 1'b1;
          end
        end
        m_pc = nxt;
        if (nxt == 32'd0) begin
          m_active = 1'b0;
          m_pend = 1'b0;
        end
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (cmp_en) begin
        chk("pc", instr_address, m_pc);
        chk("link", link_address, m_pc + 32'd8);
        chk("slot", {31'd0, in_delay_slot}, {31'd0, m_pend});
        chk("active", {31'd0, active}, {31'd0, m_active});
        chk("addr_fault", {31'd0, addr_fault}, {31'd0, m_af});
        chk("slot_fault", {31'd0, slot_fault}, {31'd0, m_sf});
        chk("count", instr_count, CountEn ? m_cnt : 32'd0);
      end
    end
  end

  // Returns 2 time units after a rising edge so inputs change well away from edges.
  task automatic tick(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic drive(input logic en, input logic rv, input logic [31:0] tgt);
    clk_enable = en;
    redirect_valid = rv;
    redirect_target = tgt;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    #1;
    reset = 1'b1;
  endtask

  initial begin
    logic [31:0] cnt_snap;
    int          halt_wait;
    #1 reset = 1'b0;
    #1;
    chk("rst_pc", instr_address, 32'hBFC00000);
    chk("rst_active", {31'd0, active}, 32'd1);
    cmp_en = 1'b1;
    tick();
    reset = 1'b1;

    // Reset / sequential
    do_reset();
    chk("seq0", instr_address, 32'hBFC00000);
    tick(); chk("seq1", instr_address, 32'hBFC00004);
    tick(); chk("seq2", instr_address, 32'hBFC00008);
    tick(); chk("seq3", instr_address, 32'hBFC0000C);
    chk("seq_link", link_address, 32'hBFC00014);
    chk("seq_cnt", instr_count, CountEn ? 32'd3 : 32'd0);

    // Delay slot
    do_reset();
    tick(2);
    drive(1'b1, 1'b1, 32'hBFC00020);
    #1 chk("br_link", link_address, 32'hBFC00010);
    tick(); drive(1'b1, 1'b0, 32'd0);
    chk("ds_pc", instr_address, 32'hBFC0000C);
    chk("ds_flag", {31'd0, in_delay_slot}, 32'd1);
    tick();
    chk("tgt_pc", instr_address, 32'hBFC00020);
    chk("tgt_flag", {31'd0, in_delay_slot}, 32'd0);

    // Halt via redirect
    do_reset();
    tick(4);
    drive(1'b1, 1'b1, 32'h00000000);
    tick(); drive(1'b1, 1'b0, 32'd0);
    chk("h_slot_pc", instr_address, 32'hBFC00014);
    chk("h_slot_act", {31'd0, active}, 32'd1);
    tick();
    chk("h_pc", instr_address, 32'h00000000);
    chk("h_act", {31'd0, active}, 32'd0);
    cnt_snap = instr_count;
    chk("h_cnt", instr_count, CountEn ? 32'd6 : 32'd0);
    drive(1'b1, 1'b1, 32'hBFC00040);
    tick(5);
    drive(1'b1, 1'b0, 32'd0);
    chk("h_pc_hold", instr_address, 32'h00000000);
    chk("h_cnt_hold", instr_count, cnt_snap);

    // Faults
    do_reset();
    drive(1'b1, 1'b1, 32'hBFC00023);
    tick(); drive(1'b1, 1'b1, 32'hBFC00040);
    tick(); drive(1'b1, 1'b0, 32'd0);
    chk("f_pc", instr_address, 32'hBFC00020);
    chk("f_af", {31'd0, addr_fault}, 32'd1);
    chk("f_sf", {31'd0, slot_fault}, 32'd1);
    tick(3);
    chk("f_pc2", instr_address, 32'hBFC0002C);
    chk("f_sticky", {30'd0, addr_fault, slot_fault}, 32'd3);

    // Enable freeze mid-branch, then reset in slot
    do_reset();
    drive(1'b1, 1'b1, 32'hBFC00100);
    tick(); drive(1'b0, 1'b1, 32'h00000000);
    tick(4);
    chk("en_pc", instr_address, 32'hBFC00004);
    chk("en_slot", {31'd0, in_delay_slot}, 32'd1);
    chk("en_cnt", instr_count, CountEn ? 32'd1 : 32'd0);
    drive(1'b1, 1'b0, 32'd0);
    tick();
    chk("en_tgt", instr_address, 32'hBFC00100);
    drive(1'b1, 1'b1, 32'hBFC00003);
    tick(); drive(1'b1, 1'b0, 32'd0);
    reset = 1'b0;
    #1;
    chk("mr_pc", instr_address, 32'hBFC00000);
    chk("mr_slot", {31'd0, in_delay_slot}, 32'd0);
    chk("mr_af", {31'd0, addr_fault}, 32'd0);
    reset = 1'b1;

    // Sequential wrap to the halt address
    drive(1'b1, 1'b1, 32'hFFFFFFF8);
    tick(); drive(1'b1, 1'b0, 32'd0);
    tick(2);
    chk("wrap_pre", instr_address, 32'hFFFFFFFC);
    tick();
    chk("wrap_pc", instr_address, 32'h00000000);
    chk("wrap_act", {31'd0, active}, 32'd0);

    // Random phase
    do_reset();
    halt_wait = 0;
    for (int i = 0; i < 3000; i++) begin
      logic [31:0] tgt;
      tgt = 32'hBFC00000 + $urandom_range(0, 1023);
      if ($urandom_range(0, 63) == 0) tgt = 32'h00000000;
      drive(($urandom_range(0, 7) != 0), ($urandom_range(0, 3) == 0), tgt);
      if (!m_active) halt_wait++;
      if ((halt_wait > 3 && $urandom_range(0, 3) == 0) || $urandom_range(0, 299) == 0) begin
        halt_wait = 0;
        do_reset();
      end
      tick();
    end

    cmp_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
